// File: rtl/ccip_c0_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ccip_c0_rd_arbiter
//  Description : Round-robin arbiter sharing the CCI-P channel-0 read-request
//                TX path among NUM_REQ internal requesters. Each issued
//                request is tagged with its requester index in the top mdata
//                bits, and returning read responses are routed back by that
//                tag. Honours c0TxAlmFull and bounds the number of in-flight
//                reads per requester.
//  Revision    : 1.0  initial release
// ============================================================================
module ccip_c0_rd_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int HDR_W           = 74,
  parameter int MDATA_W         = 16,
  parameter int MAX_OUTSTANDING = 32,
  parameter int TAG_W           = $clog2(NUM_REQ),
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       pClk,
  input  logic                       pck_cp2af_softReset_n,
  // requester side
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*HDR_W-1:0]   req_hdr,
  output logic [NUM_REQ-1:0]         req_ready,
  // CCI-P c0 TX
  output logic                       c0tx_valid,
  output logic [HDR_W-1:0]           c0tx_hdr,
  input  logic                       c0TxAlmFull,
  // CCI-P c0 RX (read responses only)
  input  logic                       c0rx_rsp_valid,
  input  logic [MDATA_W-1:0]         c0rx_mdata,
  // routed responses
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [MDATA_W-1:0]         rsp_mdata,
  // status
  output logic [NUM_REQ*CNT_W-1:0]   outstanding_cnt,
  output logic                       idle,
  output logic                       err_underflow
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [TAG_W-1:0] PTR_INIT = TAG_W'(NUM_REQ - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [TAG_W-1:0]   ptr;                 // index of the last granted requester
  logic [CNT_W-1:0]   cnt [NUM_REQ];       // in-flight reads per requester

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] cnt_zero;
  logic               grant_found;
  logic [TAG_W-1:0]   grant_idx;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant_vec;
  logic [HDR_W-1:0]   tagged_hdr;

  logic [TAG_W-1:0]   rsp_tag;
  logic               rsp_tag_ok;
  logic [NUM_REQ-1:0] rsp_hit;
  logic               rsp_zero_hit;
  logic               underflow_set;
  logic [MDATA_W-1:0] rsp_mdata_clr;
  logic [NUM_REQ-1:0] cnt_inc;
  logic [NUM_REQ-1:0] cnt_dec;

  // Per-requester eligibility and zero flags; a full counter blocks only its
  // own requester.
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
      assign eligible[i]                        = req_valid[i] & (cnt[i] < MAX_CNT);
      assign cnt_zero[i]                        = (cnt[i] == '0);
      assign outstanding_cnt[i*CNT_W +: CNT_W]  = cnt[i];
    end
  endgenerate

  // Round-robin scan: first eligible index starting at ptr+1, wrapping.
  always_comb begin
    int scan;
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = (int'(ptr) + k) % NUM_REQ;
      if (!grant_found && eligible[scan]) begin
        grant_found = 1'b1;
        grant_idx   = TAG_W'(scan);
      end
    end
  end

  // A grant only exists out of reset and when the TX path is not almost full.
  assign grant_any = grant_found & ~c0TxAlmFull & pck_cp2af_softReset_n;

  // One-hot ready vector built from the selected index.
  always_comb begin
    grant_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_any && (grant_idx == TAG_W'(i))) begin
        grant_vec[i] = 1'b1;
      end
    end
  end

  assign req_ready = grant_vec;

  // Select the granted header and stamp the requester index into the tag bits.
  always_comb begin
    tagged_hdr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == TAG_W'(i)) begin
        tagged_hdr = req_hdr[i*HDR_W +: HDR_W];
      end
    end
    tagged_hdr[MDATA_W-1 -: TAG_W] = grant_idx;
  end

  // --------------------------------------------------------------------------
  // Response decode
  // --------------------------------------------------------------------------
  assign rsp_tag    = c0rx_mdata[MDATA_W-1 -: TAG_W];
  // Tags beyond NUM_REQ-1 can only appear when NUM_REQ is not a power of two.
  assign rsp_tag_ok = (int'(rsp_tag) < NUM_REQ);

  // Decode the response tag into a one-hot hit vector and probe its counter.
  always_comb begin
    rsp_hit      = '0;
    rsp_zero_hit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (c0rx_rsp_valid && (rsp_tag == TAG_W'(i))) begin
        rsp_hit[i]   = 1'b1;
        rsp_zero_hit = cnt_zero[i];
      end
    end
  end

  assign underflow_set = c0rx_rsp_valid & (~rsp_tag_ok | rsp_zero_hit);

  // Strip the routing tag before handing mdata back to the requester.
  always_comb begin
    rsp_mdata_clr                       = c0rx_mdata;
    rsp_mdata_clr[MDATA_W-1 -: TAG_W]   = '0;
  end

  // Counter update requests; a response to an empty counter never decrements.
  assign cnt_inc = grant_vec;
  assign cnt_dec = rsp_hit & ~cnt_zero;

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Round-robin pointer follows the most recent grant.
  always_ff @(posedge pClk) begin
    if (!pck_cp2af_softReset_n) begin
      ptr <= PTR_INIT;
    end else if (grant_any) begin
      ptr <= grant_idx;
    end
  end

  // Registered request toward CCI-P; the header holds when nothing is issued.
  always_ff @(posedge pClk) begin
    if (!pck_cp2af_softReset_n) begin
      c0tx_valid <= 1'b0;
      c0tx_hdr   <= '0;
    end else begin
      c0tx_valid <= grant_any;
      if (grant_any) begin
        c0tx_hdr <= tagged_hdr;
      end
    end
  end

  // In-flight counters; simultaneous increment and decrement cancel.
  always_ff @(posedge pClk) begin
    if (!pck_cp2af_softReset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({cnt_inc[i], cnt_dec[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
          2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Routed response: one-cycle pulse, mdata captured only on a response.
  always_ff @(posedge pClk) begin
    if (!pck_cp2af_softReset_n) begin
      rsp_valid <= '0;
      rsp_mdata <= '0;
    end else begin
      rsp_valid <= rsp_hit;
      if (c0rx_rsp_valid) begin
        rsp_mdata <= rsp_mdata_clr;
      end
    end
  end

  // Sticky underflow / bad-tag error, cleared only by reset.
  always_ff @(posedge pClk) begin
    if (!pck_cp2af_softReset_n) begin
      err_underflow <= 1'b0;
    end else if (underflow_set) begin
      err_underflow <= 1'b1;
    end
  end

  // Idle when nothing is in flight and nothing is being issued.
  assign idle = (&cnt_zero) & ~c0tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_ccip_c0_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ccip_c0_rd_arbiter
//  Description : Directed self-checking bench for ccip_c0_rd_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ccip_c0_rd_arbiter;

  localparam int NUM_REQ = 4;
  localparam int HDR_W   = 74;
  localparam int MDATA_W = 16;
  localparam int MAXO    = 32;
  localparam int CNT_W   = 6;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*HDR_W-1:0] req_hdr;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     c0tx_valid;
  logic [HDR_W-1:0]         c0tx_hdr;
  logic                     alm_full;
  logic                     c0rx_rsp_valid;
  logic [MDATA_W-1:0]       c0rx_mdata;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [MDATA_W-1:0]       rsp_mdata;
  logic [NUM_REQ*CNT_W-1:0] outstanding_cnt;
  logic                     idle;
  logic                     err_underflow;

  int errors = 0;
  int checks = 0;

  ccip_c0_rd_arbiter #(
    .NUM_REQ(NUM_REQ), .HDR_W(HDR_W), .MDATA_W(MDATA_W), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .pClk                  (clk),
    .pck_cp2af_softReset_n (rst_n),
    .req_valid             (req_valid),
    .req_hdr               (req_hdr),
    .req_ready             (req_ready),
    .c0tx_valid            (c0tx_valid),
    .c0tx_hdr              (c0tx_hdr),
    .c0TxAlmFull           (alm_full),
    .c0rx_rsp_valid        (c0rx_rsp_valid),
    .c0rx_mdata            (c0rx_mdata),
    .rsp_valid             (rsp_valid),
    .rsp_mdata             (rsp_mdata),
    .outstanding_cnt       (outstanding_cnt),
    .idle                  (idle),
    .err_underflow         (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Requester header pattern; tag bits [15:14] left zero as required.
  function automatic logic [HDR_W-1:0] hdr_pat(input int i);
    logic [57:0] upper;
    logic [15:0] md;
    upper = 58'h1234_5678_9A0 + 58'(i);
    md    = 16'h0011 + 16'(i * 16'h0101);
    return {upper, md};
  endfunction

  // Header as it should appear on c0 TX after tag insertion.
  function automatic logic [HDR_W-1:0] exp_hdr(input int g);
    logic [HDR_W-1:0] h;
    h = hdr_pat(g);
    h[15:14] = 2'(g);
    return h;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_of(input int i);
    return outstanding_cnt[i*CNT_W +: CNT_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    req_valid      = '0;
    alm_full       = 1'b0;
    c0rx_rsp_valid = 1'b0;
    c0rx_mdata     = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    req_valid      = '0;
    alm_full       = 1'b0;
    c0rx_rsp_valid = 1'b0;
    c0rx_mdata     = '0;
    for (int i = 0; i < NUM_REQ; i++) req_hdr[i*HDR_W +: HDR_W] = hdr_pat(i);

    // ---------------- reset state ----------------
    tick();
    req_valid = 4'hF;
    #1;
    check("ready_in_reset", 128'(req_ready), 128'h0);
    tick();
    check("rst_c0tx_valid", 128'(c0tx_valid), 128'h0);
    check("rst_c0tx_hdr",   128'(c0tx_hdr),   128'h0);
    check("rst_rsp_valid",  128'(rsp_valid),  128'h0);
    check("rst_rsp_mdata",  128'(rsp_mdata),  128'h0);
    check("rst_cnts",       128'(outstanding_cnt), 128'h0);
    check("rst_err",        128'(err_underflow), 128'h0);
    check("rst_idle",       128'(idle), 128'h1);

    // ---------------- round robin, all valid ----------------
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rr_ready_%0d", k), 128'(req_ready), 128'(4'b0001 << (k % 4)));
      if (k > 0) begin
        check($sformatf("rr_txv_%0d", k), 128'(c0tx_valid), 128'h1);
        check($sformatf("rr_hdr_%0d", k), 128'(c0tx_hdr), 128'(exp_hdr((k - 1) % 4)));
      end
      tick();
    end
    check("rr_hdr_last", 128'(c0tx_hdr), 128'(exp_hdr(3)));
    req_valid = '0;
    #1;
    check("rr_no_ready", 128'(req_ready), 128'h0);
    tick();
    check("rr_txv_low", 128'(c0tx_valid), 128'h0);
    check("rr_hdr_hold", 128'(c0tx_hdr), 128'(exp_hdr(3)));
    check("rr_cnt0", 128'(cnt_of(0)), 128'd2);
    check("rr_cnt3", 128'(cnt_of(3)), 128'd2);
    check("rr_not_idle", 128'(idle), 128'h0);

    // ---------------- saturation on requester 2 ----------------
    apply_reset();
    req_valid = 4'b0100;
    #1;
    for (int k = 0; k < MAXO; k++) begin
      if (req_ready !== 4'b0100) check($sformatf("sat_ready_%0d", k), 128'(req_ready), 128'h4);
      tick();
    end
    check("sat_cnt2", 128'(cnt_of(2)), 128'd32);
    check("sat_blocked", 128'(req_ready), 128'h0);
    c0rx_rsp_valid = 1'b1;
    c0rx_mdata     = 16'h8123;
    tick();
    c0rx_rsp_valid = 1'b0;
    #1;
    check("sat_cnt2_dec", 128'(cnt_of(2)), 128'd31);
    check("sat_rsp_valid", 128'(rsp_valid), 128'h4);
    check("sat_rsp_mdata", 128'(rsp_mdata), 128'h0123);
    check("sat_resume", 128'(req_ready), 128'h4);
    tick();
    check("sat_cnt2_back", 128'(cnt_of(2)), 128'd32);
    check("sat_rsp_pulse", 128'(rsp_valid), 128'h0);

    // ---------------- almost full ----------------
    apply_reset();
    req_valid = 4'hF;
    #1;
    check("af_first", 128'(req_ready), 128'h1);
    tick();
    alm_full = 1'b1;
    #1;
    check("af_ready0", 128'(req_ready), 128'h0);
    check("af_prev_issues", 128'(c0tx_valid), 128'h1);
    for (int k = 1; k < 5; k++) begin
      tick();
      check($sformatf("af_ready%0d", k), 128'(req_ready), 128'h0);
      check($sformatf("af_txv%0d", k), 128'(c0tx_valid), 128'h0);
    end
    tick();
    alm_full = 1'b0;
    #1;
    check("af_resume", 128'(req_ready), 128'h2);

    // ---------------- response routing, tag 01 ----------------
    req_valid = 4'b0010;
    tick();
    check("rt_cnt1_pre", 128'(cnt_of(1)), 128'd1);
    req_valid      = '0;
    c0rx_rsp_valid = 1'b1;
    c0rx_mdata     = 16'h4ABC;
    tick();
    c0rx_rsp_valid = 1'b0;
    c0rx_mdata     = '0;
    check("rt_rsp_valid", 128'(rsp_valid), 128'h2);
    check("rt_rsp_mdata", 128'(rsp_mdata), 128'h0ABC);
    check("rt_cnt1", 128'(cnt_of(1)), 128'd0);
    check("rt_err", 128'(err_underflow), 128'h0);
    tick();
    check("rt_pulse", 128'(rsp_valid), 128'h0);

    // ---------------- simultaneous grant and response ----------------
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) tick();
    check("sim_cnt1_5", 128'(cnt_of(1)), 128'd5);
    c0rx_rsp_valid = 1'b1;
    c0rx_mdata     = 16'h4007;
    #1;
    check("sim_ready", 128'(req_ready), 128'h2);
    tick();
    c0rx_rsp_valid = 1'b0;
    req_valid      = '0;
    check("sim_cnt1_same", 128'(cnt_of(1)), 128'd5);
    check("sim_rsp_valid", 128'(rsp_valid), 128'h2);

    // ---------------- underflow, then reset mid-stream ----------------
    c0rx_rsp_valid = 1'b1;
    c0rx_mdata     = 16'hC055;
    tick();
    c0rx_rsp_valid = 1'b0;
    check("uf_err", 128'(err_underflow), 128'h1);
    check("uf_cnt3", 128'(cnt_of(3)), 128'd0);
    check("uf_rsp_valid", 128'(rsp_valid), 128'h8);
    tick();
    tick();
    check("uf_sticky", 128'(err_underflow), 128'h1);
    req_valid = 4'hF;
    tick();
    rst_n = 1'b0;
    #1;
    check("mr_ready_in_reset", 128'(req_ready), 128'h0);
    tick();
    check("mr_txv", 128'(c0tx_valid), 128'h0);
    check("mr_hdr", 128'(c0tx_hdr), 128'h0);
    check("mr_cnts", 128'(outstanding_cnt), 128'h0);
    check("mr_err", 128'(err_underflow), 128'h0);
    check("mr_rsp", 128'(rsp_valid), 128'h0);
    rst_n = 1'b1;
    #1;
    check("mr_first_grant", 128'(req_ready), 128'h1);
    req_valid      = '0;
    c0rx_rsp_valid = 1'b1;
    c0rx_mdata     = 16'h4000;
    #1;
    check("mr_no_grant", 128'(req_ready), 128'h0);
    c0rx_rsp_valid = 1'b0;
    req_valid      = 4'hF;
    #1;
    tick();
    check("mr_tx_tag0", 128'(c0tx_hdr), 128'(exp_hdr(0)));
    req_valid      = '0;
    c0rx_rsp_valid = 1'b1;
    c0rx_mdata     = 16'h4000;
    tick();
    c0rx_rsp_valid = 1'b0;
    check("mr_stale_rsp_err", 128'(err_underflow), 128'h1);
    check("mr_cnt0", 128'(cnt_of(0)), 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
